// File: rtl/trap_unit.sv
// Trap unit: turns commit-stage exceptions, a synchronized external interrupt
// and mret into a three-phase sequence (accept, CSR commit, PC redirect).
// Every output comes straight from a register, so the CSR file and fetch
// see clean strobes with no combinational path from the commit stage.
module trap_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_wb,
   input  logic [31:0] pc_wb,
   input  logic [31:0] inst_wb,
   input  logic [31:0] addr_wb,
   input  logic        illegal_inst,
   input  logic        ecall,
   input  logic        l_fault,
   input  logic        s_fault,
   input  logic        mret_wb,
   input  logic        ext_int,
   input  logic [31:0] mstatus,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        trap,
   output logic        mret,
   output logic [31:0] mepc_out,
   output logic [31:0] mcause_out,
   output logic [31:0] mtval_out,
   output logic        flush,
   output logic        stall,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [15:0] trap_count
);

   // Sequencer states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_COMMIT = 2'd1;
   localparam logic [1:0] ST_REDIR  = 2'd2;

   // Kind of the event being handled
   localparam logic [2:0] K_INT   = 3'd0;
   localparam logic [2:0] K_ILL   = 3'd1;
   localparam logic [2:0] K_ECALL = 3'd2;
   localparam logic [2:0] K_LF    = 3'd3;
   localparam logic [2:0] K_SF    = 3'd4;
   localparam logic [2:0] K_MRET  = 3'd5;

   // Cause codes written to mcause
   localparam logic [31:0] CAUSE_INT   = 32'h8000_000B;
   localparam logic [31:0] CAUSE_ILL   = 32'd2;
   localparam logic [31:0] CAUSE_ECALL = 32'd11;
   localparam logic [31:0] CAUSE_LF    = 32'd5;
   localparam logic [31:0] CAUSE_SF    = 32'd7;

   // Vectored-mode offset for the machine external interrupt (4 * 11)
   localparam logic [31:0] VEC_INT_OFFSET = 32'd44;

   logic        r_intMeta;
   logic        r_intSync;
   logic [1:0]  r_state;
   logic [2:0]  r_kind;
   logic        r_trap;
   logic        r_mret;
   logic [31:0] r_mepcOut;
   logic [31:0] r_mcauseOut;
   logic [31:0] r_mtvalOut;
   logic        r_flush;
   logic        r_redirect;
   logic [31:0] r_redirectPc;
   logic [15:0] r_trapCount;

   logic        w_intPend;
   logic        w_hasCause;
   logic        w_accept;
   logic [2:0]  w_kind;
   logic [31:0] w_mepc;
   logic [31:0] w_mcause;
   logic [31:0] w_mtval;
   logic [31:0] w_vecBase;
   logic [31:0] w_redirTarget;
   logic        w_unusedMstatus;

   // Only MIE (bit 3) of mstatus matters here; fold the rest away
   assign w_unusedMstatus = ^{mstatus[31:4], mstatus[2:0]};

   // Two-flop synchronizer: ext_int arrives from another clock domain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_intMeta <= 1'b0;
         r_intSync <= 1'b0;
      end else begin
         r_intMeta <= ext_int;
         r_intSync <= r_intMeta;
      end
   end

   // An interrupt only counts as pending while globally enabled
   assign w_intPend = r_intSync & mstatus[3];

   // Pick the highest-priority cause and the CSR values it would produce
   always_comb begin
      w_hasCause = 1'b1;
      w_kind     = K_MRET;
      w_mepc     = pc_wb;
      w_mcause   = 32'd0;
      w_mtval    = 32'd0;
      if (w_intPend) begin
         w_kind   = K_INT;
         w_mcause = CAUSE_INT;
      end else if (illegal_inst) begin
         w_kind   = K_ILL;
         w_mcause = CAUSE_ILL;
         w_mtval  = inst_wb;
      end else if (ecall) begin
         w_kind   = K_ECALL;
         w_mcause = CAUSE_ECALL;
      end else if (l_fault) begin
         w_kind   = K_LF;
         w_mcause = CAUSE_LF;
         w_mtval  = addr_wb;
      end else if (s_fault) begin
         w_kind   = K_SF;
         w_mcause = CAUSE_SF;
         w_mtval  = addr_wb;
      end else if (mret_wb) begin
         w_kind   = K_MRET;
         w_mepc   = mepc;
      end else begin
         w_hasCause = 1'b0;
      end
   end

   // New events are only looked at while idle with a valid commit-stage slot
   assign w_accept = (r_state == ST_IDLE) && valid_wb && w_hasCause;

   // Redirect target: mret returns to mepc, vectored interrupts jump into the table
   assign w_vecBase = {mtvec[31:2], 2'b00};

   always_comb begin
      w_redirTarget = w_vecBase;
      if (r_kind == K_MRET) begin
         w_redirTarget = {mepc[31:2], 2'b00};
      end else if ((r_kind == K_INT) && (mtvec[1:0] == 2'b01)) begin
         w_redirTarget = w_vecBase + VEC_INT_OFFSET;
      end
   end

   // Sequencer: IDLE -> COMMIT on acceptance, then REDIR, then back to IDLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_kind  <= K_INT;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_COMMIT;
                  r_kind  <= w_kind;
               end
            end
            ST_COMMIT: r_state <= ST_REDIR;
            ST_REDIR:  r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // CSR update strobes and data, valid for exactly the COMMIT cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_trap      <= 1'b0;
         r_mret      <= 1'b0;
         r_mepcOut   <= 32'd0;
         r_mcauseOut <= 32'd0;
         r_mtvalOut  <= 32'd0;
      end else if (w_accept) begin
         r_trap      <= (w_kind != K_MRET);
         r_mret      <= (w_kind == K_MRET);
         r_mepcOut   <= w_mepc;
         r_mcauseOut <= w_mcause;
         r_mtvalOut  <= w_mtval;
      end else begin
         r_trap      <= 1'b0;
         r_mret      <= 1'b0;
         r_mepcOut   <= 32'd0;
         r_mcauseOut <= 32'd0;
         r_mtvalOut  <= 32'd0;
      end
   end

   // PC redirect, valid for exactly the REDIR cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_redirect   <= 1'b0;
         r_redirectPc <= 32'd0;
      end else if (r_state == ST_COMMIT) begin
         r_redirect   <= 1'b1;
         r_redirectPc <= w_redirTarget;
      end else begin
         r_redirect   <= 1'b0;
         r_redirectPc <= 32'd0;
      end
   end

   // Pipeline hold: flush and stall cover both COMMIT and REDIR
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flush <= 1'b0;
      end else begin
         r_flush <= w_accept || (r_state == ST_COMMIT);
      end
   end

   // Count traps taken (mret is a return, not a trap); wraps naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_trapCount <= 16'd0;
      end else if (w_accept && (w_kind != K_MRET)) begin
         r_trapCount <= r_trapCount + 16'd1;
      end
   end

   assign trap        = r_trap;
   assign mret        = r_mret;
   assign mepc_out    = r_mepcOut;
   assign mcause_out  = r_mcauseOut;
   assign mtval_out   = r_mtvalOut;
   assign flush       = r_flush;
   assign stall       = r_flush;
   assign redirect    = r_redirect;
   assign redirect_pc = r_redirectPc;
   assign trap_count  = r_trapCount;

endmodule

// File: doc/trap_unit.md
TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 The block SHALL use exactly one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- valid_wb  in  1  commit-stage instruction valid.
- pc_wb  in  32  commit-stage PC.
- inst_wb  in  32  commit-stage instruction word.
- addr_wb  in  32  commit-stage memory address.
- illegal_inst, ecall, l_fault, s_fault, mret_wb  in  1 each  commit-stage event flags.
- ext_int  in  1  asynchronous external interrupt, level.
- mstatus, mtvec, mepc  in  32 each  current CSR values.
- trap, mret  out  1 each  CSR update strobes.
- mepc_out, mcause_out, mtval_out  out  32 each  CSR update data.
- flush, stall  out  1 each  pipeline control.
- redirect  out  1  PC redirect strobe.
- redirect_pc  out  32  redirect target.
- trap_count  out  16  number of traps taken.

Function
REQ-003 ext_int SHALL pass through a two-flop synchronizer; int_s denotes its output.
REQ-004 FSM states SHALL be IDLE, COMMIT, REDIR.
- IDLE->COMMIT when an event is accepted.
- COMMIT->REDIR unconditionally.
- REDIR->IDLE unconditionally.
REQ-005 An event SHALL be accepted only in IDLE with valid_wb=1 and at least one pending cause; inputs are ignored in COMMIT and REDIR.
REQ-006 Cause priority (highest first) SHALL be:
- interrupt (int_s=1 and mstatus[3]=1);
- illegal_inst;
- ecall;
- l_fault;
- s_fault;
- mret_wb.
REQ-007 On acceptance, the block SHALL latch kind, mepc, mcause and mtval:
- interrupt: mepc=pc_wb, mcause=32'h8000000B, mtval=0.
- illegal_inst: mepc=pc_wb, mcause=2, mtval=inst_wb.
- ecall: mepc=pc_wb, mcause=11, mtval=0.
- l_fault: mepc=pc_wb, mcause=5, mtval=addr_wb.
- s_fault: mepc=pc_wb, mcause=7, mtval=addr_wb.
- mret_wb: mepc=mepc input, mcause=0, mtval=0.
REQ-008 In COMMIT, the block SHALL drive:
- trap=1 for any cause except mret_wb, or mret=1 for mret_wb (never both);
- mepc_out, mcause_out, mtval_out from the latched values;
- flush=1 and stall=1.
REQ-009 In REDIR, the block SHALL drive redirect=1, flush=1, stall=1 and redirect_pc as follows:
- mret: mepc input & ~3;
- interrupt with mtvec[1:0]==2'b01: (mtvec & ~3) + 4*11;
- all other traps: mtvec & ~3.
REQ-010 Outside COMMIT, trap, mret, mepc_out, mcause_out and mtval_out SHALL be 0; outside REDIR, redirect and redirect_pc SHALL be 0.
REQ-011 Latency SHALL be: event sampled at edge N; COMMIT strobes during cycle N+1; redirect during cycle N+2; IDLE from edge N+3. The next event is accepted no earlier than edge N+3.
REQ-012 trap_count SHALL increment by 1 on each IDLE->COMMIT transition for a non-mret cause and SHALL wrap from 16'hFFFF to 0.
REQ-013 When an interrupt is pending and mstatus[3]=0, the block SHALL take no interrupt; a simultaneous synchronous exception SHALL still be taken.
REQ-014 valid_wb=0 SHALL block acceptance regardless of flags, including a pending interrupt.
REQ-015 All outputs SHALL be registered or decoded only from registered state.

Reset
REQ-016 While rst=0, the FSM SHALL be forced to IDLE and the synchronizer flops, latched registers and trap_count SHALL be cleared, so all outputs read 0. Assertion SHALL take effect immediately, independent of clk.
REQ-017 Reset asserted in COMMIT or REDIR SHALL abort the sequence, with no further strobes after release.
REQ-018 After release, the first acceptance SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-019 Illegal instruction:
- stimulus: pc_wb=0x100, inst_wb=0xFFFFFFFF, illegal_inst=1, valid_wb=1, mtvec=0x200;
- response: cycle+1 trap=1, mepc_out=0x100, mcause_out=2, mtval_out=0xFFFFFFFF; cycle+2 redirect_pc=0x200; trap_count=1.
REQ-020 Vectored interrupt:
- stimulus: ext_int=1 held, mstatus=0x88, mtvec=0x201, valid_wb=1, pc_wb=0x40;
- response: after synchronizer, mcause_out=0x8000000B, mepc_out=0x40, redirect_pc=0x22C.
REQ-021 Masked interrupt with exception:
- stimulus: mstatus=0x80, ext_int=1, ecall=1, pc_wb=0x80;
- response: mcause_out=11, mepc_out=0x80.
REQ-022 mret:
- stimulus: mret_wb=1, mepc=0x104;
- response: mret=1 with trap=0 in COMMIT, then redirect_pc=0x104.
REQ-023 Back-to-back and reset abort:
- stimulus: illegal_inst held high for 6 cycles;
- response: exactly two acceptances, 3 cycles apart;
- stimulus: rst pulled low during REDIR;
- response: redirect=0 immediately and trap_count=0.
